clk_div_multi: RTL and testbench
================================

# clk_div_multi

Parametrised multi-channel clock divider and tick generator. It replaces fixed two-output dividers (1 Hz / kHz style) with NCH independent channels. Each channel has a runtime-programmable divisor, a per-channel enable, a common phase-restart input and glitch-free divisor updates. It sits next to the board clock and feeds the display-scan, LED-blink and key-debounce logic, using either single-cycle ticks (preferred) or 50 % square outputs.

## Interface
- CW, 26, counter/divisor width in bits.
- NCH, 2, number of channels (1..16).
- DIV_INIT, {26'd25_000, 26'd25_000_000}, packed NCH*CW reset divisors; channel i = bits [i*CW +: CW]. The default gives 1 Hz on ch0 and 1 kHz on ch1 from 50 MHz.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  NCH  per-channel run enable.
- sync  in  1  synchronous restart of all channels.
- wr_en  in  1  divisor write strobe.
- wr_ch  in  max(1,clog2(NCH))  channel select for write.
- wr_div  in  CW  new divisor.
- tick  out  NCH  one-cycle pulse per channel period.
- clk_out  out  NCH  square output, period 2*div cycles.
- pend  out  NCH  written divisor not yet active.

## Operation
- Per-channel state:
  - cnt[CW]: counter.
  - act[CW]: active divisor.
  - nxt[CW]: pending divisor.
  - pend: pending flag.
  - clk_out and tick: registered outputs.
- Reset (rst=1 at an edge) forces every channel to:
  - cnt=0, clk_out=0, tick=0, pend=0.
  - act=nxt=DIV_INIT[i].
- rst has priority over everything else.
- Terminal count (TC) is act≠0 && cnt==act-1. Each edge, in priority order:
  - rst: as above.
  - sync=1: cnt=0, clk_out=0, tick=0. act, nxt and pend are untouched.
  - act==0 (channel stopped): cnt=0, tick=0, clk_out held.
  - en[i]=0: cnt, clk_out held; tick=0.
  - TC: cnt=0, tick=1, clk_out toggles.
  - otherwise: cnt=cnt+1, tick=0.
- Writes:
  - wr_en && wr_ch==i sets nxt=wr_div and pend=1.
  - wr_ch≥NCH is ignored; no channel changes.
- Divisor transfer (act=nxt, pend=0) happens at:
  - a TC edge, or
  - any edge where act==0 and pend=1, or
  - a sync edge.
- A write in the same cycle as a transfer bypasses: act takes wr_div directly and pend stays 0.
- A write landing during en=0 waits for the next TC.
- Divisor 1: tick is high every enabled cycle and clk_out toggles every cycle.
- Divisor 0: the channel freezes (see stopped rule); pend clears on transfer.
- Counters never exceed act-1. Lowering the divisor mid-count is safe because the change applies only at TC.

## Timing
- All outputs are registered with no combinational path from inputs to outputs.
- After rst release, tick[i] first rises at the act-th edge, with en held high throughout.
- Ticks then repeat every act cycles while enabled.
- Each tick is exactly one clk cycle wide.
- clk_out[i] changes only on TC edges; duty is exactly 50 %.
- After sync, the first tick occurs act edges after the sync edge.
- en low for k cycles delays the next tick by exactly k cycles.
- pend rises the edge after wr_en and falls on the transfer edge.

## Test plan
CW=8, NCH=2, DIV_INIT ch0=4, ch1=1 for all scenarios.
- Free run after reset:
  - ch0 tick at edges 4, 8, 12.
  - clk_out0 =1 during edges 4..7, 0 during edges 8..11 (period 8).
  - ch1 tick constantly 1; clk_out1 toggles every edge.
- Write ch0 div=6 at edge 1 (cnt=1):
  - pend0=1 until edge 4.
  - ticks at 4, 10, 16.
  - Write coinciding with edge 4 TC: ticks at 4, 10 with pend0 never asserted.
- Write ch0 div=0:
  - Channel stops at the next TC; tick0 stays 0 and clk_out0 holds.
  - Then write div=3: transfer next edge, ticks at +4, +7 edges after the write.
- sync asserted at edge 6 while clk_out0=1:
  - Edge 6: clk_out0=0, cnt=0.
  - Next ticks at edges 10, 14.
- Enable and reset:
  - en[0]=0 for edges 2..4: tick shifts from 4 to 7.
  - rst at edge 9 after writing div=6: act0 returns to 4, pend0=0, next tick 4 edges after release.
- wr_ch=1 write with NCH=1 build (wr_ch width 1, value 1): ignored; ch0 ticks unchanged, pend stays 0.

Source files
------------

// File: rtl/clk_div_multi_if.sv
// Control and status bundle for clk_div_multi: run enables, restart, divisor writes,
// plus the registered tick / square / pending outputs.
interface clk_div_multi_if #(
  parameter int CW  = 26,
  parameter int NCH = 2,
  parameter int WCH = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH-1:0] en;
  logic           sync;
  logic           wr_en;
  logic [WCH-1:0] wr_ch;
  logic [CW-1:0]  wr_div;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] pend;

  modport master (
    output en, sync, wr_en, wr_ch, wr_div,
    input  tick, clk_out, pend
  );

  modport slave (
    input  en, sync, wr_en, wr_ch, wr_div,
    output tick, clk_out, pend
  );
endinterface

// File: rtl/clk_div_multi.sv
// NCH independent programmable dividers: one-cycle tick and 50 % square per channel.
// All outputs registered; a divisor write becomes active only at TC, sync or while stopped.
module clk_div_multi #(
  parameter int              CW       = 26,
  parameter int              NCH      = 2,
  parameter logic [NCH*CW-1:0] DIV_INIT = {26'd25_000, 26'd25_000_000}
) (
  input logic             clk_i,
  input logic             rst_i,
  clk_div_multi_if.slave  bus
);
  localparam int WCH = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] tick_w;
  logic [NCH-1:0] clk_w;
  logic [NCH-1:0] pend_w;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] act_q, act_d;
    logic [CW-1:0] nxt_q, nxt_d;
    logic          pend_q, pend_d;
    logic          tick_q, tick_d;
    logic          clk_q, clk_d;
    logic          wr_hit;
    logic          tc;
    logic          xfer;

    // Out-of-range channel numbers never match any i, so such writes are dropped.
    assign wr_hit = bus.wr_en && (bus.wr_ch == WCH'(i));
    assign tc     = (act_q != '0) && (cnt_q == act_q - CW'(1));

    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      nxt_d  = nxt_q;
      pend_d = pend_q;
      tick_d = 1'b0;
      clk_d  = clk_q;
      xfer   = 1'b0;
      if (bus.sync) begin
        cnt_d = '0;
        clk_d = 1'b0;
        xfer  = 1'b1;
      end else if (act_q == '0) begin
        cnt_d = '0;
        xfer  = pend_q;
      end else if (bus.en[i]) begin
        if (tc) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          clk_d  = ~clk_q;
          xfer   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      if (xfer) begin
        act_d  = nxt_q;
        pend_d = 1'b0;
      end
      // A write on a transfer edge goes straight to the active divisor.
      if (wr_hit) begin
        nxt_d = bus.wr_div;
        if (xfer) begin
          act_d = bus.wr_div;
        end else begin
          pend_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q  <= '0;
        act_q  <= DIV_INIT[i*CW +: CW];
        nxt_q  <= DIV_INIT[i*CW +: CW];
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        clk_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        nxt_q  <= nxt_d;
        pend_q <= pend_d;
        tick_q <= tick_d;
        clk_q  <= clk_d;
      end
    end

    assign tick_w[i] = tick_q;
    assign clk_w[i]  = clk_q;
    assign pend_w[i] = pend_q;
  end

  assign bus.tick    = tick_w;
  assign bus.clk_out = clk_w;
  assign bus.pend    = pend_w;
endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (CW=8, ch0 div 4, ch1 div 1, plus an NCH=1 build).
module tb_clk_div_multi;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clk_div_multi_if #(.CW(8), .NCH(2)) bus ();
  clk_div_multi_if #(.CW(8), .NCH(1)) bus1 ();

  clk_div_multi #(.CW(8), .NCH(2), .DIV_INIT({8'd1, 8'd4})) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );
  clk_div_multi #(.CW(8), .NCH(1), .DIV_INIT(8'd4)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic [1:0] en;
    logic       sync;
    logic       wr_en;
    logic       wr_ch;
    logic [7:0] wr_div;
    logic [1:0] tick;
    logic [1:0] clk_out;
    logic [1:0] pend;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(logic r, logic [1:0] en, logic s, logic we, logic wc,
                              logic [7:0] wd, logic [1:0] t, logic [1:0] c, logic [1:0] p);
    vec_t v;
    v.rst = r; v.en = en; v.sync = s; v.wr_en = we; v.wr_ch = wc; v.wr_div = wd;
    v.tick = t; v.clk_out = c; v.pend = p;
    return v;
  endfunction

  function automatic logic [63:0] bm(int a, int b, int c);
    logic [63:0] m;
    m = '0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    if (c >= 0) m[c] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] rng(int lo, int hi);
    logic [63:0] m;
    m = '0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  task automatic cmp(string nm, int e, logic [7:0] got, logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge %0d: got %0h expected %0h", nm, e, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    bus.en = 2'b11; bus.sync = 1'b0; bus.wr_en = 1'b0; bus.wr_ch = 1'b0; bus.wr_div = '0;
    bus1.en = 1'b1; bus1.sync = 1'b0; bus1.wr_en = 1'b0; bus1.wr_ch = 1'b0; bus1.wr_div = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Channel-0 scenario: up to two writes, an en[0] low window, one sync and one rst edge.
  task automatic scen(string nm, int n, int w1e, int w1d, int w2e, int w2d, int ena, int enb,
                      int se, int re, logic [63:0] tm, logic [63:0] pm, logic [63:0] cm);
    do_reset();
    for (int e = 1; e <= n; e++) begin
      bus.wr_en  = (e == w1e) || (e == w2e);
      bus.wr_div = (e == w1e) ? 8'(w1d) : 8'(w2d);
      bus.wr_ch  = 1'b0;
      bus.en     = {1'b1, !(e >= ena && e <= enb)};
      bus.sync   = (e == se);
      rst        = (e == re);
      step();
      cmp({nm, " tick0"}, e, 8'(bus.tick[0]), 8'(tm[e]));
      cmp({nm, " pend0"}, e, 8'(bus.pend[0]), 8'(pm[e]));
      cmp({nm, " clk_out0"}, e, 8'(bus.clk_out[0]), 8'(cm[e]));
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] tm1;
    idle_inputs();
    // Free run from reset, then a ch1 write that bypasses on a TC edge, then a pending ch0 write.
    tbl[0]  = mk(1, 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00);
    tbl[1]  = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b10, 2'b00);
    tbl[2]  = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b00, 2'b00);
    tbl[3]  = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b10, 2'b00);
    tbl[4]  = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b01, 2'b00);
    tbl[5]  = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b11, 2'b00);
    tbl[6]  = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b01, 2'b00);
    tbl[7]  = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b11, 2'b00);
    tbl[8]  = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b00, 2'b00);
    tbl[9]  = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b10, 2'b00);
    tbl[10] = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b00, 2'b00);
    tbl[11] = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b10, 2'b00);
    tbl[12] = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b01, 2'b00);
    tbl[13] = mk(0, 2'b11, 0, 1, 1, 8'd2, 2'b10, 2'b11, 2'b00);
    tbl[14] = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b11, 2'b00);
    tbl[15] = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b01, 2'b00);
    tbl[16] = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b00, 2'b00);
    tbl[17] = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b10, 2'b00);
    tbl[18] = mk(0, 2'b11, 0, 1, 0, 8'd6, 2'b00, 2'b10, 2'b01);
    tbl[19] = mk(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b00, 2'b01);

    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].rst; bus.en = tbl[i].en; bus.sync = tbl[i].sync;
      bus.wr_en = tbl[i].wr_en; bus.wr_ch = tbl[i].wr_ch; bus.wr_div = tbl[i].wr_div;
      step();
      cmp("tbl tick", i, 8'(bus.tick), 8'(tbl[i].tick));
      cmp("tbl clk_out", i, 8'(bus.clk_out), 8'(tbl[i].clk_out));
      cmp("tbl pend", i, 8'(bus.pend), 8'(tbl[i].pend));
    end
    idle_inputs();

    scen("wr6_mid", 17, 1, 6, -1, 0, -1, -1, -1, -1,
         bm(4, 10, 16), rng(1, 3), rng(4, 9) | rng(16, 17));
    scen("wr6_at_tc", 11, 4, 6, -1, 0, -1, -1, -1, -1,
         bm(4, 10, -1), '0, rng(4, 9));
    scen("stop_restart", 16, 1, 0, 8, 3, -1, -1, -1, -1,
         bm(4, 12, 15), rng(1, 3) | rng(8, 8), rng(4, 11) | rng(15, 16));
    scen("sync6", 14, -1, 0, -1, 0, -1, -1, 6, -1,
         bm(4, 10, 14), '0, rng(4, 5) | rng(10, 13));
    scen("en_low", 12, -1, 0, -1, 0, 2, 4, -1, -1,
         bm(7, 11, -1), '0, rng(7, 10));
    scen("rst9", 14, 1, 6, 6, 5, -1, -1, -1, 9,
         bm(4, 13, -1), rng(1, 3) | rng(6, 8), rng(4, 8) | rng(13, 14));

    // Single-channel build: a write to channel 1 does not exist and must be dropped.
    do_reset();
    tm1 = bm(4, 8, 12);
    for (int e = 1; e <= 12; e++) begin
      bus1.wr_en  = (e == 1);
      bus1.wr_ch  = 1'b1;
      bus1.wr_div = 8'd6;
      step();
      cmp("nch1 tick0", e, 8'(bus1.tick[0]), 8'(tm1[e]));
      cmp("nch1 pend0", e, 8'(bus1.pend[0]), 8'd0);
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
